// File: rtl/comp_link_pkg.sv
// Shared definitions for the comparator fiber link receive path.
package comp_link_pkg;

  // K characters carried in the low byte of the frame marker
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;

  // Alignment state of the deframer
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // Width of an assembled frame: 16 bits per payload word
  function automatic int frame_width(input int data_words);
    return 16 * data_words;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear overrides a same-cycle increment.
module sat_counter
  import comp_link_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         REC_CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_reg;

  // Count events, hold at all-ones, clear has priority
  always_ff @(posedge REC_CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (CLR) begin
      q_reg <= '0;
    end else if (INC && !(&q_reg)) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/comp_frame_rx.sv
// Deframer for the comparator fiber link: marker-based alignment with a
// hunt/verify/locked flywheel, payload assembly and link error counters.
module comp_frame_rx
  import comp_link_pkg::*;
#(
  parameter int         DATA_WORDS = 3,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 2,
  parameter logic [7:0] LTNCY_K    = K28_7,
  parameter int         CNT_W      = 16
) (
  input  logic                                REC_CLK,
  input  logic                                RST,
  input  logic                                RX_SYNC_DONE,
  input  logic [15:0]                         RX_DATA,
  input  logic [1:0]                          RX_ISK,
  input  logic [1:0]                          RX_NOTINTABLE,
  input  logic [1:0]                          RX_DISPERR,
  input  logic                                CNT_CLR,
  output logic [frame_width(DATA_WORDS)-1:0]  FRAME_DATA,
  output logic                                FRAME_VALID,
  output logic                                LTNCY_TRIG,
  output logic [DATA_WORDS:0]                 CEW,
  output logic                                LOCKED,
  output logic [CNT_W-1:0]                    CODE_ERR_CNT,
  output logic [CNT_W-1:0]                    FRAME_ERR_CNT
);

  localparam int FW    = frame_width(DATA_WORDS);
  localparam int POS_W = $clog2(DATA_WORDS + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_WORDS);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  // The port LOCKED hides the enum literal of the same name
  localparam rx_state_t ST_LOCKED = comp_link_pkg::LOCKED;

  logic is_marker, is_k, code_err;
  assign is_marker = (RX_ISK == 2'b01);
  assign is_k      = |RX_ISK;
  assign code_err  = |(RX_NOTINTABLE | RX_DISPERR);

  rx_state_t        state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next, pos_adv;
  logic [3:0]       good_reg, good_next, miss_reg, miss_next;
  logic             frame_err;

  assign pos_adv = (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;

  // Alignment flywheel: next state, word position and good/miss tallies
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    good_next  = good_reg;
    miss_next  = miss_reg;
    frame_err  = 1'b0;
    if (!RX_SYNC_DONE) begin
      state_next = HUNT;
      pos_next   = '0;
      good_next  = '0;
      miss_next  = '0;
    end else begin
      case (state_reg)
        HUNT: begin
          if (is_marker) begin
            pos_next   = POS_W'(1);
            good_next  = 4'd1;
            miss_next  = '0;
            state_next = (LOCK_N == 4'd1) ? ST_LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (pos_reg == '0) begin
            if (is_marker) begin
              good_next = good_reg + 4'd1;
              pos_next  = pos_adv;
              if (good_reg + 4'd1 == LOCK_N) state_next = ST_LOCKED;
            end else begin
              state_next = HUNT;
              pos_next   = '0;
              good_next  = '0;
            end
          end else if (is_marker) begin
            // A marker in the wrong place means the alignment was false
            state_next = HUNT;
            pos_next   = '0;
            good_next  = '0;
          end else begin
            pos_next = pos_adv;
          end
        end
        ST_LOCKED: begin
          pos_next = pos_adv;
          if (pos_reg == '0) begin
            if (is_marker) begin
              miss_next = '0;
            end else begin
              frame_err = 1'b1;
              miss_next = miss_reg + 4'd1;
              if (miss_reg + 4'd1 == UNLOCK_N) begin
                state_next = HUNT;
                pos_next   = '0;
                miss_next  = '0;
                good_next  = '0;
              end
            end
          end else if (is_k) begin
            // Stray K inside the payload: flag it but keep the flywheel phase
            frame_err = 1'b1;
          end
        end
        default: begin
          state_next = HUNT;
          pos_next   = '0;
          good_next  = '0;
          miss_next  = '0;
        end
      endcase
    end
  end

  // Alignment state registers
  always_ff @(posedge REC_CLK) begin
    if (RST) begin
      state_reg <= HUNT;
      pos_reg   <= '0;
      good_reg  <= '0;
      miss_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      good_reg  <= good_next;
      miss_reg  <= miss_next;
    end
  end

  // Payload capture: slots 1..D-1 are stored, the last word is taken live
  logic          capture;
  logic [FW-1:0] assembled;
  assign capture = RX_SYNC_DONE && (state_reg != HUNT);

  for (genvar gi = 0; gi < DATA_WORDS; gi++) begin : g_slot
    if (gi < DATA_WORDS - 1) begin : g_store
      logic [15:0] word_reg;
      // Hold payload word gi+1 until the frame completes
      always_ff @(posedge REC_CLK) begin
        if (RST) begin
          word_reg <= '0;
        end else if (capture && (pos_reg == POS_W'(gi + 1))) begin
          word_reg <= RX_DATA;
        end
      end
      assign assembled[16*gi +: 16] = word_reg;
    end else begin : g_last
      assign assembled[16*gi +: 16] = RX_DATA;
    end
  end

  // Frame qualification carried across the frame's words
  logic frame_ok_reg, frame_ok_next, ltncy_reg, ltncy_next;
  logic frame_load, valid_next;

  // Qualify the frame: locked present marker, then no error or K in any word
  always_comb begin
    frame_ok_next = frame_ok_reg;
    ltncy_next    = ltncy_reg;
    frame_load    = 1'b0;
    valid_next    = 1'b0;
    if (pos_reg == '0) begin
      frame_ok_next = is_marker && !code_err && (state_next == ST_LOCKED);
      ltncy_next    = (RX_DATA[7:0] == LTNCY_K);
    end else begin
      frame_ok_next = frame_ok_reg && !code_err && !is_k;
    end
    if (capture && (pos_reg == POS_LAST)) begin
      frame_load = 1'b1;
      valid_next = frame_ok_next;
    end
  end

  logic [FW-1:0] frame_data_reg;
  logic          frame_valid_reg, ltncy_trig_reg;

  // Output frame registers
  always_ff @(posedge REC_CLK) begin
    if (RST) begin
      frame_ok_reg    <= 1'b0;
      ltncy_reg       <= 1'b0;
      frame_valid_reg <= 1'b0;
      ltncy_trig_reg  <= 1'b0;
      frame_data_reg  <= '0;
    end else begin
      frame_ok_reg    <= frame_ok_next;
      ltncy_reg       <= ltncy_next;
      frame_valid_reg <= valid_next;
      ltncy_trig_reg  <= valid_next && ltncy_next;
      if (frame_load) frame_data_reg <= assembled;
    end
  end

  assign FRAME_DATA  = frame_data_reg;
  assign FRAME_VALID = frame_valid_reg;
  assign LTNCY_TRIG  = ltncy_trig_reg;
  assign LOCKED      = (state_reg == ST_LOCKED);

  // Word-position strobes, silent while hunting
  for (genvar gi = 0; gi <= DATA_WORDS; gi++) begin : g_cew
    assign CEW[gi] = (state_reg != HUNT) && (pos_reg == POS_W'(gi));
  end

  sat_counter #(.W(CNT_W)) u_code_cnt (
    .REC_CLK (REC_CLK),
    .RST     (RST),
    .CLR     (CNT_CLR),
    .INC     (code_err),
    .Q       (CODE_ERR_CNT)
  );

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .REC_CLK (REC_CLK),
    .RST     (RST),
    .CLR     (CNT_CLR),
    .INC     (frame_err),
    .Q       (FRAME_ERR_CNT)
  );

endmodule

// File: tb/tb_comp_frame_rx.sv
// Self-checking bench for comp_frame_rx with a frame-level reference model.
module tb_comp_frame_rx;

  localparam int D      = 3;
  localparam int FW     = 16 * D;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_done;
  logic [15:0]   rx_data;
  logic [1:0]    rx_isk, rx_nit, rx_disp;
  logic          cnt_clr;
  logic [FW-1:0] frame_data;
  logic          frame_valid, ltncy_trig, locked;
  logic [D:0]    cew;
  logic [15:0]   code_cnt, frame_cnt;

  always #3 clk = ~clk;

  comp_frame_rx #(
    .DATA_WORDS (D),
    .LOCK_CNT   (LOCK),
    .UNLOCK_CNT (UNLOCK),
    .LTNCY_K    (8'hFC),
    .CNT_W      (16)
  ) dut (
    .REC_CLK       (clk),
    .RST           (rst),
    .RX_SYNC_DONE  (sync_done),
    .RX_DATA       (rx_data),
    .RX_ISK        (rx_isk),
    .RX_NOTINTABLE (rx_nit),
    .RX_DISPERR    (rx_disp),
    .CNT_CLR       (cnt_clr),
    .FRAME_DATA    (frame_data),
    .FRAME_VALID   (frame_valid),
    .LTNCY_TRIG    (ltncy_trig),
    .CEW           (cew),
    .LOCKED        (locked),
    .CODE_ERR_CNT  (code_cnt),
    .FRAME_ERR_CNT (frame_cnt)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: link status at frame granularity (0 hunt, 1 verify, 2 locked)
  int m_st = 0, m_good = 0, m_miss = 0;
  int exp_code = 0, exp_frame = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Apply the marker-slot rules for one aligned frame
  task automatic model_marker(input bit mk);
    if (m_st == 0) begin
      if (mk) begin
        m_good = 1;
        m_st   = (LOCK == 1) ? 2 : 1;
      end
    end else if (m_st == 1) begin
      if (mk) begin
        m_good++;
        if (m_good == LOCK) m_st = 2;
      end else begin
        m_st   = 0;
        m_good = 0;
      end
    end else begin
      if (mk) m_miss = 0;
      else begin
        m_miss++;
        exp_frame = sat_inc(exp_frame);
        if (m_miss == UNLOCK) begin
          m_st   = 0;
          m_miss = 0;
        end
      end
    end
  endtask

  // Send one aligned frame (marker slot + D payload words) and check every word
  task automatic send_frame(input bit mk, input logic [7:0] mk_lo, input int err_pos,
                            input logic [3:0] err_val, input int k_pos, input string tag);
    logic [15:0]   w [0:D];
    logic [FW-1:0] exp_data;
    logic [D:0]    exp_cew;
    logic [3:0]    e;
    int            st0;
    bit            exp_valid;
    w[0] = mk ? {8'h00, mk_lo} : 16'($urandom);
    for (int k = 1; k <= D; k++) begin
      w[k] = 16'($urandom);
      exp_data[16*(k-1) +: 16] = w[k];
    end
    st0 = m_st;
    model_marker(mk);
    exp_valid = mk && (m_st == 2) && !(err_pos >= 0 && err_pos <= D) && !(k_pos >= 1 && k_pos <= D);
    if (m_st == 2 && k_pos >= 1 && k_pos <= D) exp_frame = sat_inc(exp_frame);
    for (int k = 0; k <= D; k++) begin
      exp_cew = '0;
      if (k == 0) begin
        if (st0 != 0) exp_cew[0] = 1'b1;
      end else if (m_st != 0) begin
        exp_cew[k] = 1'b1;
      end
      check({tag, "/cew"}, 64'(cew), 64'(exp_cew));
      rx_data = w[k];
      rx_isk  = (k == 0 && mk) ? 2'b01 : ((k == k_pos) ? 2'b10 : 2'b00);
      if (k == err_pos) begin
        e = (err_val != 4'd0) ? err_val : 4'($urandom_range(1, 15));
        {rx_nit, rx_disp} = e;
        exp_code = sat_inc(exp_code);
      end else begin
        {rx_nit, rx_disp} = 4'd0;
      end
      @(posedge clk); #1;
      check({tag, "/locked"}, 64'(locked), 64'(m_st == 2));
      check({tag, "/valid"}, 64'(frame_valid), 64'(k == D && exp_valid));
      check({tag, "/ltncy"}, 64'(ltncy_trig), 64'(k == D && exp_valid && mk_lo == 8'hFC));
    end
    rx_isk = 2'b00;
    {rx_nit, rx_disp} = 4'd0;
    if (exp_valid) check({tag, "/data"}, 64'(frame_data), 64'(exp_data));
    check({tag, "/code_cnt"}, 64'(code_cnt), 64'(exp_code));
    check({tag, "/frame_cnt"}, 64'(frame_cnt), 64'(exp_frame));
    $display("frame %-10s mk=%0d lo=%02h err@%0d k@%0d locked=%0d valid=%0d code=%0d ferr=%0d",
             tag, mk, mk_lo, err_pos, k_pos, locked, frame_valid, code_cnt, frame_cnt);
  endtask

  // Start a frame, then kill it with reset or a sync drop after the first payload word
  task automatic abort_frame(input bit use_rst, input string tag);
    rx_isk = 2'b01; rx_data = 16'h00BC;
    @(posedge clk); #1;
    rx_isk = 2'b00; rx_data = 16'($urandom);
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else sync_done = 1'b0;
    rx_data = 16'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    sync_done = 1'b1;
    m_st = 0; m_good = 0; m_miss = 0;
    if (use_rst) begin
      exp_code  = 0;
      exp_frame = 0;
      check({tag, "/fdata0"}, 64'(frame_data), 64'd0);
    end
    check({tag, "/locked"}, 64'(locked), 64'd0);
    check({tag, "/cew"}, 64'(cew), 64'd0);
    check({tag, "/valid"}, 64'(frame_valid), 64'd0);
    rx_data = 16'($urandom);
    @(posedge clk); #1;
    check({tag, "/valid_end"}, 64'(frame_valid), 64'd0);
    check({tag, "/code_cnt"}, 64'(code_cnt), 64'(exp_code));
    check({tag, "/frame_cnt"}, 64'(frame_cnt), 64'(exp_frame));
    $display("abort %-10s rst=%0d locked=%0d valid=%0d", tag, use_rst, locked, frame_valid);
  endtask

  initial begin
    int n;
    rst = 1'b1; sync_done = 1'b1; rx_data = '0; rx_isk = '0;
    rx_nit = '0; rx_disp = '0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/fdata", 64'(frame_data), 64'd0);
    check("rst/valid", 64'(frame_valid), 64'd0);
    check("rst/ltncy", 64'(ltncy_trig), 64'd0);
    check("rst/cew", 64'(cew), 64'd0);
    check("rst/locked", 64'(locked), 64'd0);
    check("rst/code_cnt", 64'(code_cnt), 64'd0);
    check("rst/frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;

    // Acquire lock on six clean frames
    for (int i = 0; i < 6; i++) send_frame(1'b1, 8'hBC, -1, 4'd0, -1, "lock");
    send_frame(1'b1, 8'hFC, -1, 4'd0, -1, "ltncy");
    send_frame(1'b1, 8'hBC, 2, 4'b0001, -1, "disperr");
    send_frame(1'b0, 8'hBC, -1, 4'd0, -1, "miss1");
    send_frame(1'b1, 8'hBC, -1, 4'd0, -1, "after_miss");
    send_frame(1'b0, 8'hBC, -1, 4'd0, -1, "miss2a");
    send_frame(1'b0, 8'hBC, -1, 4'd0, -1, "miss2b");

    // Relock, then abort mid-frame with reset and with a sync drop
    for (int i = 0; i < 5; i++) send_frame(1'b1, 8'hBC, -1, 4'd0, -1, "relock");
    abort_frame(1'b1, "abort_rst");
    for (int i = 0; i < 5; i++) send_frame(1'b1, 8'hFC, -1, 4'd0, -1, "relock2");
    send_frame(1'b1, 8'hBC, 0, 4'b0100, -1, "mk_err");
    send_frame(1'b1, 8'hBC, -1, 4'd0, 3, "stray_k");
    abort_frame(1'b0, "abort_sync");

    // Randomized frames
    for (int i = 0; i < 60; i++) begin
      bit         mk;
      logic [7:0] lo;
      int         ep, kp;
      mk = ($urandom_range(0, 7) != 0);
      lo = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'hBC;
      ep = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, D)) : -1;
      kp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, D)) : -1;
      send_frame(mk, lo, ep, 4'd0, kp, "random");
    end

    // Saturate the code error counter while held out of alignment
    sync_done = 1'b0;
    m_st = 0; m_good = 0; m_miss = 0;
    n = 65535 - exp_code + 3;
    rx_disp = 2'b01;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
    exp_code = 65535;
    check("sat/code_cnt", 64'(code_cnt), 64'(exp_code));
    check("sat/locked", 64'(locked), 64'd0);
    check("sat/cew", 64'(cew), 64'd0);
    $display("burst sat errors=%0d code=%0h", n, code_cnt);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    exp_code = 0; exp_frame = 0;
    check("clr/code_cnt", 64'(code_cnt), 64'(exp_code));
    check("clr/frame_cnt", 64'(frame_cnt), 64'(exp_frame));
    cnt_clr = 1'b0;
    rx_disp = 2'b00;
    @(posedge clk); #1;
    check("clr/hold", 64'(code_cnt), 64'(exp_code));
    $display("clear code=%0d ferr=%0d", code_cnt, frame_cnt);
    sync_done = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
